seq_detector_param: RTL

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_det_pkg.sv | 59 +++++
 rtl/sat_counter.sv | 22 ++
 rtl/seq_detector_param.sv | 53 +++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Elaboration-time helpers for the serial pattern detector: derives the
// prefix-automaton next-state table and full-match failure state from a pattern.
package seq_det_pkg;

   localparam int MAX_LEN = 8;

   typedef struct packed {
      logic [MAX_LEN-1:0][1:0][2:0] nxt;   // [state][x] -> next state
      logic [2:0]                   fail;  // longest proper border of the full pattern
   } det_tbl_t;

   // Pattern bit j counted from the first-received (MSB) end.
   function automatic logic pat_bit(input logic [7:0] pat, input int len, input int j);
      logic [7:0] t;
      t = pat >> (len - 1 - j);
      return t[0];
   endfunction

   function automatic det_tbl_t build_tbl(input logic [7:0] pat, input int len);
      det_tbl_t r;
      int       best;
      logic     ok;
      logic     sb;
      r = '0;
      for (int s = 0; s < MAX_LEN; s++) begin
         for (int b = 0; b < 2; b++) begin
            best = 0;
            if (s < len) begin
               // Candidate string is the matched prefix of length s followed by b.
               for (int l = 1; l < len; l++) begin
                  if (l <= s + 1) begin
                     ok = 1'b1;
                     for (int j = 0; j < l; j++) begin
                        sb = (s + 1 - l + j < s) ? pat_bit(pat, len, s + 1 - l + j) : b[0];
                        if (sb != pat_bit(pat, len, j))
                           ok = 1'b0;
                     end
                     if (ok)
                        best = l;
                  end
               end
            end
            r.nxt[3'(s)][1'(b)] = 3'(best);
         end
      end
      best = 0;
      for (int l = 1; l < len; l++) begin
         ok = 1'b1;
         for (int j = 0; j < l; j++)
            if (pat_bit(pat, len, len - l + j) != pat_bit(pat, len, j))
               ok = 1'b0;
         if (ok)
            best = l;
      end
      r.fail = 3'(best);
      return r;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Latency: q updates on the edge after inc/clr. No backpressure.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         cp,
   input  logic         rd,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   always_ff @(posedge cp or posedge rd) begin
      if (rd)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (inc && (q != {W{1'b1}}))
         q <= q + 1'b1;
   end

endmodule

// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with overlap select and match counter.
// Latency: z registered on the edge consuming the completing bit. Stalls via en.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int             LEN     = 4,
   parameter logic [LEN-1:0] PATTERN = 4'b1011,
   parameter int             COUNT_W = 8
) (
   input  logic                    cp,
   input  logic                    rd,
   input  logic                    x,
   input  logic                    en,
   input  logic                    overlap,
   input  logic                    clr,
   output logic                    z,
   output logic [$clog2(LEN)-1:0]  state,
   output logic [COUNT_W-1:0]      match_cnt
);

   localparam int       SW  = $clog2(LEN);
   localparam det_tbl_t TBL = build_tbl(8'(PATTERN), LEN);

   logic [2:0] idx;
   logic [2:0] nxt_raw;
   logic       match;

   assign idx     = 3'(state);
   assign nxt_raw = TBL.nxt[idx][x];
   assign match   = en && (state == SW'(LEN - 1)) && (x == PATTERN[0]);

   always_ff @(posedge cp or posedge rd) begin
      if (rd) begin
         state <= '0;
         z     <= 1'b0;
      end else begin
         z <= match;
         if (match)
            state <= overlap ? SW'(TBL.fail) : '0;
         else if (en)
            state <= SW'(nxt_raw);
      end
   end

   sat_counter #(.W(COUNT_W)) u_cnt (
      .cp  (cp),
      .rd  (rd),
      .inc (match),
      .clr (clr),
      .q   (match_cnt)
   );

endmodule
